// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding,
// default reset PC and the next-PC source selection.
package fetch_stage_pkg;

    // All-zero word decodes as a NOP; it is what a squashed IF/ID slot holds.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Source of the next program counter, in priority order.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INCR     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // A resolved branch/jump outranks the hazard unit's hold request.
    function automatic pc_sel_e select_pc(input logic redirect, input logic pc_write);
        if (redirect) begin
            return PC_REDIRECT;
        end else if (pc_write) begin
            return PC_INCR;
        end
        return PC_HOLD;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard-unit controls, redirect bus, instruction-memory port and
// IF/ID outputs seen by the fetch stage.
interface fetch_stage_if #(
    parameter int PC_WIDTH       = 32,
    parameter int IMEM_ADDR_BITS = 8
);
    logic                      pc_write;
    logic                      if_id_write;
    logic                      if_id_flush;
    logic                      redirect;
    logic [PC_WIDTH-1:0]       redirect_target;
    logic [IMEM_ADDR_BITS-1:0] imem_addr;
    logic [31:0]               imem_rdata;
    logic [PC_WIDTH-1:0]       pc;
    logic [31:0]               if_id_instr;
    logic [PC_WIDTH-1:0]       if_id_pc4;
    logic                      if_id_valid;
    logic [31:0]               fetch_count;

    // Fetch stage side.
    modport slave (
        input  pc_write, if_id_write, if_id_flush, redirect, redirect_target, imem_rdata,
        output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count
    );

    // Pipeline / memory side driving the fetch stage.
    modport master (
        output pc_write, if_id_write, if_id_flush, redirect, redirect_target, imem_rdata,
        input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit, with write
// enable and a flush that inserts a bubble.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_en,
    input  logic                flush,
    input  logic [31:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc4_in,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc4,
    output logic                valid
);

    // Flush beats write enable; a flushed slot keeps its old pc4.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (write_en) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, instruction
// memory addressing, IF/ID register and a count of fetched instructions.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter int                  IMEM_ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target_aligned;
    logic [PC_WIDTH-1:0] pc_next;
    logic [31:0]         fetch_count_q;
    pc_sel_e             pc_sel;
    logic                squash;
    logic                load_valid;

    // Wraps naturally at 2^PC_WIDTH.
    assign pc_plus4       = pc_q + PC_WIDTH'(4);
    // Misaligned targets are silently forced onto a word boundary.
    assign target_aligned = bus.redirect_target & ~PC_WIDTH'(3);
    assign pc_sel         = select_pc(bus.redirect, bus.pc_write);

    // A taken redirect kills whatever is being fetched this cycle.
    assign squash     = bus.redirect | bus.if_id_flush;
    assign load_valid = ~squash & bus.if_id_write;

    // Next-PC multiplexer.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches
        // even if a select value is left out of the case.
        pc_next = pc_q;
        unique case (pc_sel)
            PC_REDIRECT: pc_next = target_aligned;
            PC_INCR:     pc_next = pc_plus4;
            PC_HOLD:     pc_next = pc_q;
            default:     pc_next = pc_q;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Count real instructions entering IF/ID; wraps at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else if (load_valid) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    fetch_stage_if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (bus.if_id_write),
        .flush    (squash),
        .instr_in (bus.imem_rdata),
        .pc4_in   (pc_plus4),
        .instr    (bus.if_id_instr),
        .pc4      (bus.if_id_pc4),
        .valid    (bus.if_id_valid)
    );

    assign bus.imem_addr   = pc_q[IMEM_ADDR_BITS+1:2];
    assign bus.pc          = pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: free run, stall, redirect, aligned
// redirect over a hold, PC wrap, flush, and asynchronous reset mid-stall.
module tb_fetch_stage;

    localparam int PC_WIDTH       = 32;
    localparam int IMEM_ADDR_BITS = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] rom [0:255];

    fetch_stage_if #(
        .PC_WIDTH       (PC_WIDTH),
        .IMEM_ADDR_BITS (IMEM_ADDR_BITS)
    ) bus ();

    fetch_stage #(
        .PC_WIDTH       (PC_WIDTH),
        .RESET_PC       (32'h0000_0000),
        .IMEM_ADDR_BITS (IMEM_ADDR_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Combinational instruction ROM.
    assign bus.imem_rdata = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".instr"}, 64'(bus.if_id_instr), 64'(instr));
        check({tag, ".pc4"},   64'(bus.if_id_pc4),   64'(pc4));
        check({tag, ".valid"}, 64'(bus.if_id_valid), 64'(valid));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 32'hDEAD_0000 | 32'(i);
        rom[0]   = 32'h0000_0011;
        rom[1]   = 32'h0000_0022;
        rom[2]   = 32'h0000_0033;
        rom[16]  = 32'h0000_00A0;
        rom[255] = 32'h0000_0FF0;

        rst                 = 1'b1;
        bus.pc_write        = 1'b0;
        bus.if_id_write     = 1'b0;
        bus.if_id_flush     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        repeat (2) step();

        // Reset state.
        check("rst.pc", 64'(bus.pc), 64'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst.count", 64'(bus.fetch_count), 64'h0);

        // Free run.
        rst             = 1'b0;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        #1;
        check("run0.imem_addr", 64'(bus.imem_addr), 64'h0);
        step();
        check("run1.pc", 64'(bus.pc), 64'h4);
        check_ifid("run1", 32'h11, 32'h4, 1'b1);
        check("run1.count", 64'(bus.fetch_count), 64'h1);
        step();
        check("run2.pc", 64'(bus.pc), 64'h8);
        check_ifid("run2", 32'h22, 32'h8, 1'b1);
        check("run2.count", 64'(bus.fetch_count), 64'h2);

        // Load-use stall at PC=8.
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        step();
        check("stall.pc", 64'(bus.pc), 64'h8);
        check_ifid("stall", 32'h22, 32'h8, 1'b1);
        check("stall.count", 64'(bus.fetch_count), 64'h2);

        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        step();
        check("run3.pc", 64'(bus.pc), 64'hC);
        check_ifid("run3", 32'h33, 32'hC, 1'b1);
        check("run3.count", 64'(bus.fetch_count), 64'h3);

        // Redirect to 0x40 while PC=12.
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        check("redir.pc", 64'(bus.pc), 64'h40);
        check_ifid("redir", 32'h0, 32'hC, 1'b0);
        check("redir.count", 64'(bus.fetch_count), 64'h3);
        bus.redirect = 1'b0;
        step();
        check("tgt.pc", 64'(bus.pc), 64'h44);
        check_ifid("tgt", 32'hA0, 32'h44, 1'b1);
        check("tgt.count", 64'(bus.fetch_count), 64'h4);

        // Redirect with hold and misaligned target: redirect wins, aligned.
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h43;
        bus.pc_write        = 1'b0;
        bus.if_id_write     = 1'b0;
        step();
        check("align.pc", 64'(bus.pc), 64'h40);
        check_ifid("align", 32'h0, 32'h44, 1'b0);
        check("align.count", 64'(bus.fetch_count), 64'h4);

        // Jump to the top of the address space, then wrap.
        bus.redirect_target = 32'hFFFF_FFFC;
        bus.pc_write        = 1'b1;
        bus.if_id_write     = 1'b1;
        step();
        check("top.pc", 64'(bus.pc), 64'hFFFF_FFFC);
        check("top.imem_addr", 64'(bus.imem_addr), 64'hFF);
        bus.redirect = 1'b0;
        step();
        check("wrap.pc", 64'(bus.pc), 64'h0);
        check_ifid("wrap", 32'hFF0, 32'h0, 1'b1);
        check("wrap.count", 64'(bus.fetch_count), 64'h5);

        // Flush alone inserts a bubble while the PC keeps advancing.
        bus.if_id_flush = 1'b1;
        step();
        check("flush.pc", 64'(bus.pc), 64'h4);
        check_ifid("flush", 32'h0, 32'h0, 1'b0);
        check("flush.count", 64'(bus.fetch_count), 64'h5);
        bus.if_id_flush = 1'b0;
        step();
        check("post_flush.pc", 64'(bus.pc), 64'h8);
        check_ifid("post_flush", 32'h22, 32'h8, 1'b1);
        check("post_flush.count", 64'(bus.fetch_count), 64'h6);

        // Asynchronous reset in the middle of a stall cycle.
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        step();
        check("pre_rst.pc", 64'(bus.pc), 64'h8);
        #2;
        rst = 1'b1;
        #1;
        check("arst.pc", 64'(bus.pc), 64'h0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        check("arst.count", 64'(bus.fetch_count), 64'h0);

        // Restart fetching from the reset PC.
        step();
        rst             = 1'b0;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        step();
        check("restart.pc", 64'(bus.pc), 64'h4);
        check_ifid("restart", 32'h11, 32'h4, 1'b1);
        check("restart.count", 64'(bus.fetch_count), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipelined CPU. It holds the program counter, drives the instruction-memory read address, and owns the IF/ID pipeline register. It sits directly upstream of the hazard unit's decode-side consumers and obeys its PcWrite / IF_IDWrite / Stall decisions. It takes branch/jump redirects resolved in MEM and squashes wrong-path fetches.

## Interface

Parameters:
- `PC_WIDTH`, 32: width of PC and targets.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `IMEM_ADDR_BITS`, 8: word-address width of instruction memory.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `pc_write`  input  1  from hazard unit; 0 holds PC.
- `if_id_write`  input  1  from hazard unit; 0 holds IF/ID register.
- `if_id_flush`  input  1  squash IF/ID contents (bubble).
- `redirect`  input  1  taken BEQ or J resolved in MEM.
- `redirect_target`  input  PC_WIDTH  new fetch address.
- `imem_addr`  output  IMEM_ADDR_BITS  word address to instruction ROM.
- `imem_rdata`  input  32  instruction word, combinational read.
- `pc`  output  PC_WIDTH  current fetch PC.
- `if_id_instr`  output  32  registered instruction.
- `if_id_pc4`  output  PC_WIDTH  registered PC+4 of that instruction.
- `if_id_valid`  output  1  1 = real instruction, 0 = bubble.
- `fetch_count`  output  32  number of valid instructions loaded into IF/ID.

## Operation

- `imem_addr` = `pc[IMEM_ADDR_BITS+1:2]`. This is combinational; the instruction is returned in the same cycle.
- Next-PC priority, highest first:
  - `redirect` loads `{redirect_target[PC_WIDTH-1:2],2'b00}`, even if `pc_write`=0.
  - Else, `pc_write`=1 loads `pc+4`. This is modulo 2^PC_WIDTH; 0xFFFF_FFFC wraps to 0.
  - Else, PC holds.
- IF/ID priority, highest first:
  - `redirect` or `if_id_flush` loads the bubble: instr=32'h0 (NOP), valid=0, pc4 holds. This applies even if `if_id_write`=0.
  - Else, `if_id_write`=1 loads instr=`imem_rdata`, pc4=`pc+4`, valid=1.
  - Else, the register holds.
- `fetch_count` increments (wrapping at 2^32) on every edge where IF/ID loads with valid=1. It holds otherwise.
- Targets with nonzero low two bits are silently aligned. No exception is raised.
- Load-use stall, i.e. `pc_write`=0 with `if_id_write`=0: the PC and IF/ID register both freeze. The same instruction is presented again on the next cycle.

## Timing

- Reset values (asynchronous, immediate on `rst`):
  - `pc`=RESET_PC
  - `if_id_instr`=0
  - `if_id_pc4`=0
  - `if_id_valid`=0
  - `fetch_count`=0
- The first fetch at RESET_PC occurs in the first cycle after `rst` deasserts. Its instruction appears on `if_id_*` after the next rising edge.
- Fetch latency is 1 cycle: IF/ID outputs at edge N+1 reflect the PC at edge N.
- Redirect penalty is applied at the edge where `redirect`=1:
  - PC becomes the target.
  - IF/ID becomes a bubble.
  - The target instruction is in IF/ID one edge later.
- `rst` asserted mid-stall or mid-redirect overrides everything. There is no partial update.
- No combinational path exists from `pc_write`, `if_id_write`, `if_id_flush` or `redirect` to any output except through registers.

## Structure

- The NOP encoding (32'h0) and RESET_PC default go in the shared `define/` include alongside the instruction IDs.
- One natural sub-module: `if_id_reg`. It contains the IF/ID register with write-enable and flush, and the valid bit.
- The PC register, next-PC mux and `fetch_count` stay in `fetch_stage`.

## Test plan

- Reset, then free-run with `pc_write`=`if_id_write`=1 and a ROM holding words 0x11,0x22,0x33 → PC 0,4,8,12 on successive cycles. IF/ID shows 0x11 with pc4=4, then 0x22 with pc4=8. `fetch_count` reaches 3.
- Stall one cycle (`pc_write`=`if_id_write`=0) while PC=8 → PC stays 8 and IF/ID keeps 0x22 for 2 cycles. `fetch_count` does not increment during the stall.
- `redirect`=1, `redirect_target`=0x40 while PC=12 → next cycle PC=0x40 and IF/ID valid=0, instr=0. One cycle later IF/ID holds ROM[16], valid=1.
- `redirect` and `pc_write`=0 together, with target 0x43 → PC=0x40 (aligned, redirect wins) and IF/ID is a bubble.
- PC preloaded near the top of the address space (0xFFFF_FFFC via redirect), then run → next PC=0, and `if_id_pc4`=0 for that instruction.
- Assert `rst` asynchronously mid-cycle during a stall → all outputs take their reset values immediately, without waiting for a clock edge.
